approx_rc_adder_pipe: RTL and testbench

- Parametrised, pipelined successor of the 8-bit approximate ripple-carry adder.
- The low APPROX_BITS positions use approximate cell 255_1: S = X&Y&Z, Cout = 1.
- The upper positions use exact full adders.
- The carry chain is cut into STAGES registered segments behind a valid/ready elastic pipeline, and a per-transaction mode bit selects approximate or exact arithmetic.
- It sits between operand sources and datapath consumers in the approximate-arithmetic evaluation fabric.

---
 rtl/approx_rc_adder_pipe.sv | 166 ++++++++++++++++
 tb/tb_approx_rc_adder_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_rc_adder_pipe.sv
// Pipelined approximate ripple-carry adder: low APPROX_BITS use cell S=X&Y&Z, Cout=1 unless in_exact.
// Optional error monitor (err_dist, max_err) enabled by defining APPROX_ERR_MON_EN.
module approx_rc_adder_pipe #(
  parameter int W           = 8,
  parameter int APPROX_BITS = 7,
  parameter int STAGES      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [W:0]   err_dist,
  output logic [W:0]   max_err
`endif
);

  localparam int SEG_W = W / STAGES;
  localparam int LAST  = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] carry_q, carry_d;
  logic              exact_q [STAGES];
  logic              exact_d [STAGES];
  logic [W-1:0]      a_q     [STAGES];
  logic [W-1:0]      a_d     [STAGES];
  logic [W-1:0]      b_q     [STAGES];
  logic [W-1:0]      b_d     [STAGES];
  logic [W-1:0]      sum_q   [STAGES];
  logic [W-1:0]      sum_d   [STAGES];
  logic [W:0]        seg;

  // Evaluates only the bit positions owned by segment seg_idx; other sum bits pass through.
  function automatic logic [W:0] seg_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] sum_in, input logic cin,
                                         input logic ex, input int seg_idx);
    logic [W-1:0] s;
    logic         c;
    s = sum_in;
    c = cin;
    for (int i = 0; i < W; i++) begin
      if (i / SEG_W == seg_idx) begin
        if (!ex && i < APPROX_BITS) begin
          s[i] = a[i] & b[i] & c;
          c    = 1'b1;
        end else begin
          s[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
      end
    end
    return {c, s};
  endfunction

  always_comb begin
    adv     = '0;
    vld_d   = vld_q;
    carry_d = carry_q;
    exact_d = exact_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    seg     = '0;

    adv[LAST] = !vld_q[LAST] || out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = !vld_q[s] || adv[s+1];
    end

    // Stage 0: lowest segment straight from the operands, carry-in 0.
    if (adv[0]) begin
      seg        = seg_add(in_a, in_b, '0, 1'b0, in_exact, 0);
      vld_d[0]   = in_valid;
      exact_d[0] = in_exact;
      a_d[0]     = in_a;
      b_d[0]     = in_b;
      sum_d[0]   = seg[W-1:0];
      carry_d[0] = seg[W];
    end

    // Stages 1..LAST: continue the chain from the previous stage's registered carry.
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) begin
        seg        = seg_add(a_q[s-1], b_q[s-1], sum_q[s-1], carry_q[s-1], exact_q[s-1], s);
        vld_d[s]   = vld_q[s-1];
        exact_d[s] = exact_q[s-1];
        a_d[s]     = a_q[s-1];
        b_d[s]     = b_q[s-1];
        sum_d[s]   = seg[W-1:0];
        carry_d[s] = seg[W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    carry_q <= carry_d;
    exact_q <= exact_d;
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[LAST];
  // Data registers are not reset, so the result is masked while the output is empty.
  assign out_sum   = vld_q[LAST] ? {carry_q[LAST], sum_q[LAST]} : '0;

`ifdef APPROX_ERR_MON_EN
  logic [W:0] exact_sum_q [STAGES];
  logic [W:0] exact_sum_d [STAGES];
  logic [W:0] max_err_q, max_err_d;
  logic [W:0] err_dist_c;

  always_comb begin
    exact_sum_d = exact_sum_q;
    if (adv[0]) begin
      exact_sum_d[0] = {1'b0, in_a} + {1'b0, in_b};
    end
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) begin
        exact_sum_d[s] = exact_sum_q[s-1];
      end
    end

    err_dist_c = '0;
    if (out_valid) begin
      err_dist_c = (out_sum >= exact_sum_q[LAST]) ? out_sum - exact_sum_q[LAST]
                                                  : exact_sum_q[LAST] - out_sum;
    end

    max_err_d = max_err_q;
    if (out_valid && out_ready && err_dist_c > max_err_q) begin
      max_err_d = err_dist_c;
    end
  end

  always_ff @(posedge clk) begin
    exact_sum_q <= exact_sum_d;
    if (rst) begin
      max_err_q <= '0;
    end else begin
      max_err_q <= max_err_d;
    end
  end

  assign err_dist = err_dist_c;
  assign max_err  = max_err_q;
`endif

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Self-checking bench for approx_rc_adder_pipe (default build and APPROX_ERR_MON_EN build).
module tb_approx_rc_adder_pipe;
  localparam int W   = 8;
  localparam int AB  = 7;
  localparam int ST  = 2;
  localparam int W2  = 16;
  localparam int ST2 = 4;
  localparam int AB2 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_exact, out_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic [W:0]   out_sum;
  logic          v2, r2, ex2, ov2, or2;
  logic [W2-1:0] a2, b2;
  logic [W2:0]   s2;
`ifdef APPROX_ERR_MON_EN
  logic [W:0]  err_dist, max_err;
  logic [W2:0] err2, max2;
`endif

  int errors = 0;
  int checks = 0;
  int max_model = 0;

  approx_rc_adder_pipe #(.W(W), .APPROX_BITS(AB), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef APPROX_ERR_MON_EN
    , .err_dist(err_dist), .max_err(max_err)
`endif
  );

  approx_rc_adder_pipe #(.W(W2), .APPROX_BITS(AB2), .STAGES(ST2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2),
    .in_exact(ex2), .out_valid(ov2), .out_ready(or2), .out_sum(s2)
`ifdef APPROX_ERR_MON_EN
    , .err_dist(err2), .max_err(max2)
`endif
  );

  // Reference: approximate cells force carry 1 into every position above bit 0,
  // so the low part is a&b (bit 0 gets carry-in 0) and the exact upper part sees carry-in 1.
  function automatic int model(input int a, input int b, input bit ex, input int ab);
    int mask, low, high;
    if (ex || ab == 0) return a + b;
    mask = (1 << ab) - 1;
    low  = a & b & mask & ~1;
    high = ((a >> ab) + (b >> ab) + 1) << ab;
    return low + high;
  endfunction

  function automatic int absdiff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b1;
    v2 = 1'b0; a2 = '0; b2 = '0; ex2 = 1'b0; or2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (ov2 !== 1'b0 || r2 !== 1'b1) begin errors++; $display("FAIL reset_w16: got ov=%b rdy=%b want 0/1", ov2, r2); end
`ifdef APPROX_ERR_MON_EN
    checks++; if (max_err !== '0) begin errors++; $display("FAIL reset_max_err: got %0d want 0", max_err); end
`endif
    max_model = 0;
  endtask

  task automatic test_directed();
    int ta [6] = '{'h00, 'h00, 'hFF, 'hFF, 'h0F, 'h0F};
    int tb [6] = '{'h00, 'h00, 'hFF, 'hFF, 'h01, 'h01};
    int te [6] = '{0, 1, 0, 1, 0, 1};
    int tr [6] = '{'h080, 'h000, 'h1FE, 'h1FE, 'h080, 'h010};
    int terr [6] = '{128, 0, 0, 0, 112, 0};
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = W'(ta[i]); in_b = W'(tb[i]); in_exact = te[i][0];
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1 in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early[%0d]: got out_valid=%b want 0", i, out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== (W+1)'(tr[i])) begin
        errors++; $display("FAIL dir_sum[%0d]: got v=%b sum=%h want v=1 sum=%h", i, out_valid, out_sum, tr[i]);
      end
`ifdef APPROX_ERR_MON_EN
      checks++; if (err_dist !== (W+1)'(terr[i])) begin errors++; $display("FAIL dir_err[%0d]: got %0d want %0d", i, err_dist, terr[i]); end
      if (terr[i] > max_model) max_model = terr[i];
`endif
      @(posedge clk); #1;
`ifdef APPROX_ERR_MON_EN
      checks++; if (max_err !== (W+1)'(max_model)) begin errors++; $display("FAIL dir_max_err[%0d]: got %0d want %0d", i, max_err, max_model); end
`endif
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1 out_ready = 1'b0; in_exact = 1'b1; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    @(posedge clk); #1 in_a = 8'd2; in_b = 8'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2: got %b want 1", in_ready); end
    @(posedge clk); #1 in_a = 8'd3; in_b = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 9'h002) begin
        errors++; $display("FAIL bp_full[%0d]: got rdy=%b v=%b sum=%h want 0/1/002", k, in_ready, out_valid, out_sum);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_sum !== 9'h002) begin
      errors++; $display("FAIL bp_release: got rdy=%b v=%b sum=%h want 1/1/002", in_ready, out_valid, out_sum);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_sum !== 9'h004) begin errors++; $display("FAIL bp_second: got v=%b sum=%h want 1/004", out_valid, out_sum); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_sum !== 9'h006) begin errors++; $display("FAIL bp_third: got v=%b sum=%h want 1/006", out_valid, out_sum); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got v=%b want 0", out_valid); end
  endtask

  task automatic test_stream(input int n, input bit jitter);
    int expq [$];
    int errq [$];
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1, e = 0, ee = 0;
    bit acc, hold_pend = 1'b0;
    logic [W:0] hold_val = '0;
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b0;
    while (got < n && cyc < n * 20 + 50) begin
      if (!in_valid && sent < n && (!jitter || ($urandom % 3) != 0)) begin
        in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_exact = 1'($urandom); sent++;
      end
      if (jitter) out_ready = (($urandom % 3) != 0);
      @(negedge clk);
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== hold_val) begin
          errors++; $display("FAIL stream_hold: got v=%b sum=%h want 1/%h", out_valid, out_sum, hold_val);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = out_sum;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL stream_extra: got sum=%h want no output", out_sum);
        end else begin
          e = expq.pop_front(); ee = errq.pop_front();
          if (out_sum !== (W+1)'(e)) begin errors++; $display("FAIL stream_sum[%0d]: got %h want %h", got, out_sum, e); end
`ifdef APPROX_ERR_MON_EN
          checks++;
          if (err_dist !== (W+1)'(ee) || max_err !== (W+1)'(max_model)) begin
            errors++; $display("FAIL stream_err[%0d]: got err=%0d max=%0d want %0d/%0d", got, err_dist, max_err, ee, max_model);
          end
          if (ee > max_model) max_model = ee;
`endif
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        e = model(int'(in_a), int'(in_b), in_exact, AB);
        expq.push_back(e);
        errq.push_back(absdiff(e, int'(in_a) + int'(in_b)));
      end
      @(posedge clk); #1 cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != n) begin errors++; $display("FAIL stream_count: got %0d want %0d", got, n); end
    if (!jitter) begin
      checks++; if (first != ST) begin errors++; $display("FAIL stream_latency: got %0d want %0d", first, ST); end
      checks++; if (last - first != n - 1) begin errors++; $display("FAIL stream_rate: got span %0d want %0d", last - first, n - 1); end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6; in_exact = 1'b0;
    @(posedge clk); #1 in_a = 8'd7; in_b = 8'd8;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded: got v=%b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got v=%b sum=%h rdy=%b want 0/0/1", out_valid, out_sum, in_ready);
    end
`ifdef APPROX_ERR_MON_EN
    checks++; if (max_err !== '0) begin errors++; $display("FAIL mid_max_err: got %0d want 0", max_err); end
`endif
    max_model = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got v=%b want 0", k, out_valid); end
    end
  endtask

  task automatic test_exact_sweep();
    int expq [$];
    int sent = 0, got = 0, cyc = 0, first = -1, e = 0;
    bit acc;
    @(posedge clk); #1 or2 = 1'b1; v2 = 1'b0;
    while (got < 16 && cyc < 200) begin
      if (!v2 && sent < 16) begin
        v2 = 1'b1; a2 = W2'($urandom); b2 = W2'($urandom); ex2 = sent[0]; sent++;
      end
      @(negedge clk);
      if (ov2) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL w16_extra: got %h want no output", s2);
        end else begin
          e = expq.pop_front();
          if (s2 !== (W2+1)'(e)) begin errors++; $display("FAIL w16_sum[%0d]: got %h want %h", got, s2, e); end
`ifdef APPROX_ERR_MON_EN
          checks++; if (err2 !== '0) begin errors++; $display("FAIL w16_err[%0d]: got %0d want 0", got, err2); end
`endif
        end
        if (first < 0) first = cyc;
        got++;
      end
      acc = v2 && r2;
      if (acc) expq.push_back(model(int'(a2), int'(b2), ex2, AB2));
      @(posedge clk); #1 cyc++;
      if (acc) v2 = 1'b0;
    end
    v2 = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL w16_count: got %0d want 16", got); end
    checks++; if (first != ST2) begin errors++; $display("FAIL w16_latency: got %0d want %0d", first, ST2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream(20, 1'b0);
    test_stream(40, 1'b1);
    test_reset_midflight();
    test_stream(10, 1'b0);
    test_exact_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
